regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter and sequencer for the single write port of the 32-entry register file. Up to NUM_REQ requesters (ALU writeback, load return, etc.) present write requests. The block grants one per cycle and registers the winner's address, data and one-hot 5:32 select. The register file consumes that registered select directly as its per-register write enables.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- DATA_WIDTH, 32, width of register data
- ZERO_REG_WRITABLE, 0, when 0, writes to address 0 are accepted but suppressed

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  5*NUM_REQ  destination register; requester i in bits [5i+4:5i]
- req_data  input  DATA_WIDTH*NUM_REQ  write data; requester i in slice i
- req_ready  output  NUM_REQ  combinational grant; transfer when valid & ready
- rf_hold  input  1  register file busy; blocks all grants this cycle
- wr_enable  output  1  registered write strobe to register file
- wr_select  output  32  registered one-hot decode of wr_addr, gated by wr_enable
- wr_addr  output  5  registered destination register
- wr_data  output  DATA_WIDTH  registered write data
- grant_id  output  clog2(NUM_REQ)  registered index of the requester that produced the current write

## Operation
- Reset state:
  - rr_ptr = 0.
  - wr_enable = 0, wr_select = 0, wr_addr = 0, wr_data = 0, grant_id = 0.
  - req_ready = 0 while reset is asserted.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping at NUM_REQ-1 → 0.
  - The first valid index is the winner.
  - req_ready[winner] = 1 only if rf_hold = 0 and reset = 0. All other ready bits are 0.
  - At most one ready bit is high per cycle.
- Transfer: req_valid[w] & req_ready[w] at a rising edge.
  - rr_ptr ← (w+1) mod NUM_REQ.
  - wr_addr ← req_addr[w], wr_data ← req_data[w], grant_id ← w.
  - wr_enable ← 1, except 0 if req_addr[w] = 0 and ZERO_REG_WRITABLE = 0.
  - wr_select ← one-hot(req_addr[w]) if wr_enable is set, else all zeros.
- No transfer (no valid, or rf_hold = 1):
  - wr_enable ← 0, wr_select ← 0.
  - wr_addr, wr_data, grant_id hold their previous values.
  - rr_ptr unchanged.
- Requester rules:
  - Once valid is raised, addr/data stay stable and valid stays high until the transfer.
  - The arbiter does not check this; the bench asserts it.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- Zero-register suppression counts as a transfer for handshake and rr_ptr, but issues no write.
- wr_select is always either all zeros or exactly one bit set, matching wr_addr.

## Timing
- Latency: transfer edge N → wr_enable/wr_select valid for the cycle after edge N; the register file writes at edge N+1.
- Throughput: one write per cycle when rf_hold = 0; wr_enable may stay high on consecutive cycles.
- wr_enable is a per-transfer pulse. It is never held across cycles without a new transfer.
- rf_hold affects grants in the same cycle only. It does not retract a write already registered on the outputs.
- Back-to-back writes to the same address from different requesters are issued in grant order; later data wins in the register file.
- Simultaneous requests: only the winner transfers; losers keep valid asserted.
- Reset asserted mid-operation:
  - All outputs and rr_ptr clear immediately (asynchronous).
  - A transfer coinciding with reset is discarded.
  - Requesters must re-present requests after reset.
- rr_ptr wraps: winner NUM_REQ-1 → rr_ptr = 0.

## Test plan
- Reset: drive reset high mid-stream with all valid high → all outputs 0 and req_ready = 0 immediately. After release, the first grant goes to requester 0.
- Single requester: req_valid = 4'b0100, addr = 5'd17, data = 32'hDEADBEEF → req_ready = 4'b0100 same cycle. Next cycle: wr_enable = 1, wr_select = 32'h0002_0000, wr_addr = 17, grant_id = 2. The following cycle wr_enable = 0.
- Round-robin: all four valid continuously, addrs 1..4 → grants in order 0,1,2,3,0. wr_select sequence is 0x2, 0x4, 0x8, 0x10, 0x2, one per cycle with no bubbles.
- Hold: all valid, rf_hold = 1 for 3 cycles → req_ready = 0 and wr_enable = 0 for those cycles, rr_ptr unchanged. Grants resume with the previously pending winner.
- Zero register: requester 1 writes addr 0 → req_ready[1] = 1, next cycle wr_enable = 0 and wr_select = 0. rr_ptr advances to 2. With ZERO_REG_WRITABLE = 1: wr_enable = 1, wr_select = 32'h1.
- Random stress: 10k cycles of random valid/addr/data/rf_hold against a scoreboard model. Checks:
  - wr_select is all zeros or exactly one bit set, matching wr_addr.
  - No requester starves beyond NUM_REQ transfers.
  - Every accepted write appears exactly once, in grant order.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter for the register file write port; registers the winning write as address, data, one-hot select and grant id.
// Latency: the grant is combinational in the request cycle, and the write outputs are valid the cycle after the transfer edge.
// Backpressure: rf_hold or reset blocks every req_ready bit; losing and held requesters keep their requests pending.
module regfile_write_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int ZERO_REG_WRITABLE = 0,
  localparam int ID_W             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [5*NUM_REQ-1:0]            req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            rf_hold,
  output logic                            wr_enable,
  output logic [31:0]                     wr_select,
  output logic [4:0]                      wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [ID_W-1:0]                 grant_id
);

  logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;
  logic                  wr_enable_q, wr_enable_d;
  logic [31:0]           wr_select_q, wr_select_d;
  logic [4:0]            wr_addr_q,   wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic [ID_W-1:0]       grant_id_q,  grant_id_d;

  logic                  found;
  int                    win_idx;
  int                    idx;
  logic                  xfer;
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Find the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Grant the winner unless the register file is busy or reset is active.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    if (found && !rf_hold && !reset) begin
      req_ready[win_idx] = 1'b1;
      xfer               = 1'b1;
    end
    sel_addr = req_addr[win_idx*5 +: 5];
    sel_data = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state: capture the winner on a transfer; otherwise the strobe drops and the payload holds.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    grant_id_d  = grant_id_q;
    wr_enable_d = 1'b0;
    wr_select_d = '0;
    if (xfer) begin
      rr_ptr_d    = (win_idx == NUM_REQ - 1) ? '0 : ID_W'(win_idx + 1);
      wr_addr_d   = sel_addr;
      wr_data_d   = sel_data;
      grant_id_d  = ID_W'(win_idx);
      // A write to r0 still completes the handshake but produces no write strobe.
      wr_enable_d = (sel_addr != 5'd0) || (ZERO_REG_WRITABLE != 0);
      wr_select_d = wr_enable_d ? (32'd1 << sel_addr) : 32'd0;
    end
  end

  // State registers; reset clears everything immediately, including any transfer on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      wr_enable_q <= 1'b0;
      wr_select_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_id_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_enable_q <= wr_enable_d;
      wr_select_q <= wr_select_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign wr_enable = wr_enable_q;
  assign wr_select = wr_select_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
// Bench for regfile_write_arbiter: directed scenarios plus random stress against a queue-based reference model.
// Two instances differ only in ZERO_REG_WRITABLE and share every input.
// The model predicts each transfer's write record; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [DW*N-1:0] req_data;
  logic            rf_hold;

  logic [N-1:0]  rdy0, rdy1;
  logic          en0, en1;
  logic [31:0]   sel0, sel1;
  logic [4:0]    wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic [1:0]    gid0, gid1;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ZERO_REG_WRITABLE(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy0), .rf_hold(rf_hold), .wr_enable(en0), .wr_select(sel0), .wr_addr(wa0),
    .wr_data(wd0), .grant_id(gid0));

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ZERO_REG_WRITABLE(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy1), .rf_hold(rf_hold), .wr_enable(en1), .wr_select(sel1), .wr_addr(wa1),
    .wr_data(wd1), .grant_id(gid1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        en0, en1;
    logic [31:0] sel0, sel1;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  gid;
  } rec_t;

  rec_t exp_q[$];
  int   m_rr;
  int   wait_cnt[N];

  // Winner = valid requester at the smallest circular distance from the pointer.
  function automatic logic [N-1:0] model_ready(input int rr, input logic [N-1:0] v, input logic hold);
    logic [N-1:0] r;
    int best, bd;
    r = '0; best = -1; bd = N;
    if (!hold) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && ((i - rr + N) % N) < bd) begin
          bd = (i - rr + N) % N;
          best = i;
        end
      end
      if (best >= 0) r[best] = 1'b1;
    end
    return r;
  endfunction

  // Reference model: on each edge, predict the transfer and queue the expected write.
  logic [N-1:0] m_r;
  int           m_w;
  rec_t         m_rec;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rr = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      m_r = model_ready(m_rr, req_valid, rf_hold);
      if (m_r != '0) begin
        m_w = 0;
        for (int i = 0; i < N; i++) if (m_r[i]) m_w = i;
        m_rec.addr = req_addr[m_w*5 +: 5];
        m_rec.data = req_data[m_w*DW +: DW];
        m_rec.gid  = 2'(m_w);
        m_rec.en1  = 1'b1;
        m_rec.sel1 = 32'h1 << m_rec.addr;
        m_rec.en0  = (m_rec.addr != 5'd0);
        m_rec.sel0 = m_rec.en0 ? m_rec.sel1 : 32'h0;
        exp_q.push_back(m_rec);
        for (int i = 0; i < N; i++) begin
          if (i == m_w) wait_cnt[i] = 0;
          else if (req_valid[i]) begin
            wait_cnt[i]++;
            chk("starve", 64'(wait_cnt[i] <= N - 1), 64'd1);
          end else wait_cnt[i] = 0;
        end
        m_rr = (m_w + 1) % N;
      end
    end
  end

  // Monitor: compares the grant each cycle and the registered write after each handshake.
  logic         xfer_prev;
  logic [4:0]   last_addr;
  logic [31:0]  last_data;
  logic [1:0]   last_gid;
  logic [N-1:0] pv, pg, exp_r;
  logic [5*N-1:0]  pa;
  logic [DW*N-1:0] pd;
  rec_t         mon_rec;
  always @(negedge clk) begin
    if (reset) begin
      xfer_prev = 1'b0; last_addr = '0; last_data = '0; last_gid = '0; pv = '0; pg = '0;
      chk("rst_ready", {rdy0, rdy1}, 64'd0);
      chk("rst_outs", {en0, en1, wa0, wa1, gid0, gid1}, 64'd0);
      chk("rst_sel_data", {sel0, wd0}, 64'd0);
    end else begin
      exp_r = model_ready(m_rr, req_valid, rf_hold);
      chk("ready0", rdy0, exp_r);
      chk("ready1", rdy1, exp_r);
      if (xfer_prev) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 64'd1, 64'd0);
        end else begin
          mon_rec = exp_q.pop_front();
          chk("wr_enable0", en0, mon_rec.en0);
          chk("wr_select0", sel0, mon_rec.sel0);
          chk("wr_enable1", en1, mon_rec.en1);
          chk("wr_select1", sel1, mon_rec.sel1);
          chk("wr_payload0", {wa0, wd0, gid0}, {mon_rec.addr, mon_rec.data, mon_rec.gid});
          chk("wr_payload1", {wa1, wd1, gid1}, {mon_rec.addr, mon_rec.data, mon_rec.gid});
          last_addr = mon_rec.addr; last_data = mon_rec.data; last_gid = mon_rec.gid;
        end
      end else begin
        chk("idle_enable", {en0, en1}, 64'd0);
        chk("idle_select", {sel0, sel1}, 64'd0);
        chk("held0", {wa0, wd0, gid0}, {last_addr, last_data, last_gid});
        chk("held1", {wa1, wd1, gid1}, {last_addr, last_data, last_gid});
      end
      chk("sel_onehot", 64'($countones(sel0) <= 1 && $countones(sel1) <= 1), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (pv[i] && !pg[i]) begin
          chk("req_stable", {req_valid[i], req_addr[i*5 +: 5], req_data[i*DW +: DW]},
              {1'b1, pa[i*5 +: 5], pd[i*DW +: DW]});
        end
      end
      xfer_prev = |(req_valid & rdy0);
      pv = req_valid; pg = req_valid & rdy0; pa = req_addr; pd = req_data;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Keep each pending request until it is granted, then drop it.
  task automatic drain();
    logic [N-1:0] g;
    int n;
    n = 0;
    while (req_valid != '0 && n < 64) begin
      @(negedge clk);
      g = req_valid & rdy0;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~g;
      n++;
    end
    chk("drain_timeout", req_valid, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int          rr_order[5] = '{0, 1, 2, 3, 0};
  logic [31:0] rr_sel[5]   = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h2};
  logic [N-1:0] g;

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rf_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {en0, sel0, wa0, gid0, rdy0}, 64'd0);
    chk("reset_data", wd0, 64'd0);
    reset = 1'b0;

    // Round-robin with all four continuously valid.
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", rdy0, 64'(1 << rr_order[k]));
      cycle();
      chk("rr_select", sel0, rr_sel[k]);
      chk("rr_grant", gid0, 64'(rr_order[k]));
    end
    drain();

    // Single requester.
    set_req(2, 5'd17, 32'hDEADBEEF);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", rdy0, 64'b0100);
    cycle();
    req_valid = '0;
    chk("single_out", {en0, sel0, wa0, gid0}, {1'b1, 32'h0002_0000, 5'd17, 2'd2});
    chk("single_data", wd0, 64'hDEADBEEF);
    cycle();
    chk("single_pulse", en0, 64'd0);

    // Hold for three cycles, then the pending winner (requester 3) resumes.
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 8), 32'hB000_0000 + i);
    req_valid = '1;
    rf_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready", rdy0, 64'd0);
      cycle();
      chk("hold_enable", en0, 64'd0);
    end
    rf_hold = 1'b0;
    #1;
    chk("hold_resume", rdy0, 64'b1000);
    drain();

    // Zero register write from requester 1.
    set_req(1, 5'd0, 32'h5555_5555);
    req_valid = 4'b0010;
    #1;
    chk("zero_ready", rdy0, 64'b0010);
    cycle();
    req_valid = '0;
    chk("zero_suppr", {en0, sel0}, 64'd0);
    chk("zero_writable", {en1, sel1}, {1'b1, 32'h1});
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 20), 32'hC000_0000 + i);
    req_valid = '1;
    #1;
    chk("zero_rr_adv", rdy0, 64'b0100);

    // Reset mid-stream with everyone valid.
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    chk("midrst_outs", {en0, en1, sel0, wa0, gid0}, 64'd0);
    chk("midrst_ready", {rdy0, rdy1}, 64'd0);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("post_rst_grant", rdy0, 64'b0001);

    // Random stress; requesters obey the hold-until-transfer rule.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      g = req_valid & rdy0;
      @(posedge clk);
      #1;
      rf_hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || g[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
        end
      end
    end
    rf_hold = 1'b0;
    drain();
    cycle();
    cycle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
